next_pc_ctrl: RTL and testbench
===============================

# next_pc_ctrl

Parametrised next-PC controller for the fetch stage. It owns the architectural PC register and selects the next fetch address each cycle from these sources: sequential, predicted branch, mispredict recovery, register/immediate jump redirect, interrupt vector and interrupt return. It adds a multi-line edge-triggered interrupt controller with sticky pending bits, a per-line mask, a fixed vector table and a saved return PC (EPC), so interrupt entry and exit are handled entirely at fetch.

## Interface
- XLEN, 32: PC / address width.
- NUM_IRQ, 4: number of interrupt request lines (1..16).
- RESET_PC, 0: PC value after reset.
- VEC_BASE, 32'h100: address of vector 0.
- VEC_STRIDE, 16: byte distance between vectors; must be a power of two.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC (front end stalled).
- branch_predict  in  1  predicted-taken branch; load branch_pc.
- branch_pc  in  XLEN  predicted target.
- branch_undo  in  1  mispredict recovery; load pc_not_taken.
- pc_not_taken  in  XLEN  recovery address.
- pcr_take  in  1  register-jump redirect; load pcr.
- pcr  in  XLEN  register-jump target.
- pci_take  in  1  immediate-jump redirect; load pci.
- pci  in  XLEN  immediate-jump target.
- irq  in  NUM_IRQ  level request lines, sampled for rising edges.
- irq_mask  in  NUM_IRQ  1 = line masked (pending kept, not taken).
- eret  in  1  return from interrupt.
- pc  out  XLEN  current fetch PC (registered).
- in_isr  out  1  handler active.
- irq_taken  out  1  one-cycle pulse coincident with PC = vector.
- irq_id  out  clog2(NUM_IRQ) (min 1)  line being serviced, held until next entry.
- epc  out  XLEN  saved return address.

## Operation
- Next-PC priority, highest first: branch_undo > pcr_take > pci_take > interrupt entry > eret (only when in_isr) > stall (hold) > branch_predict > pc+4.
- Redirects (undo/pcr/pci) override stall. branch_predict is ignored under stall.
- pc+4 wraps modulo 2^XLEN. Vector address = VEC_BASE + id*VEC_STRIDE, truncated to XLEN.
- Edge detect: irq_q holds the previous irq. A pending bit sets when irq & ~irq_q.
- Pending bits are sticky. They clear only when their line is acknowledged. A new edge on the same line in the ack cycle leaves that bit set.
- Eligible = pending & ~irq_mask. The lowest index wins.
- Entry occurs when all of the following hold: state IDLE, eligible ≠ 0, no stall, no redirect. Entry does:
  - epc := branch_pc if branch_predict, else pc+4.
  - pc := vector.
  - state := ISR; irq_id := winner; winner's pending bit clears.
- Entry blocked by a stall or redirect is retried the next cycle. The pending bit stays set.
- State machine:
  - IDLE → ISR on entry.
  - ISR → IDLE on eret with no redirect; pc := epc.
  - eret in IDLE is ignored.
  - No nesting: while in ISR, eligible lines stay pending.
- Redirects inside ISR update pc normally and do not change state or epc.
- eret under stall (no redirect) takes effect, because it has priority over stall.

## Timing
- Reset values: pc = RESET_PC, in_isr = 0, irq_taken = 0, irq_id = 0, epc = 0, pending = 0, irq_q = 0, state IDLE.
- Reset is asynchronous. Asserting it mid-ISR or mid-stall returns everything to reset values immediately. The first update occurs on the first rising clk edge after rst deasserts.
- Control and address inputs are sampled at the rising edge. pc reflects the selection one cycle later (latency 1).
- irq latency: rising edge of irq sampled at edge N sets pending at N. The earliest entry is at edge N+1, where pc = vector and irq_taken = 1 for that cycle.
- Masked → unmasked: entry at the first edge where the bit is eligible and entry conditions hold.
- in_isr updates at the same edge as pc (entry and eret).

## Test plan
- Reset / sequential:
  - Stimulus: rst high with RESET_PC = 0, then release.
  - Required: pc = 0, 4, 8, …; all other outputs 0.
  - Also: pc = 32'hFFFF_FFFC then advances to 0.
- Priority:
  - Stimulus: branch_undo, pcr_take, pci_take, branch_predict and stall all high, with pc_not_taken = 20, pcr = 40, pci = 30, branch_pc = 10.
  - Required: pc = 20. Dropping undo → 40, then → 30. With stall alone, pc holds. With branch_predict alone → 10.
- Interrupt entry / return:
  - Stimulus: IDLE at pc = 0x40, irq[2] rises.
  - Required: next edge pc = 0x120, irq_taken pulses, irq_id = 2, in_isr = 1, epc = 0x44.
  - Then: eret two cycles later → pc = 0x44, in_isr = 0.
- Masking and arbitration:
  - Stimulus: irq[1] and irq[3] rise together, with irq_mask[1] = 1.
  - Required: line 3 taken (vector 0x130). After eret, unmasking line 1 gives entry to 0x110.
  - Also: a second edge arriving during ISR is not taken until after eret.
- Deferral:
  - Stimulus: pending irq[0] with stall held 3 cycles, then pcr_take for 1 cycle.
  - Required: no entry during those 4 cycles; pc holds, then pc = pcr. Entry to 0x100 on the following edge with epc = pcr+4.
- Reset mid-ISR:
  - Stimulus: assert rst between clock edges while in_isr = 1.
  - Required: outputs return to reset values immediately; a pending line that is still held high is not re-taken unless it produces a new rising edge.

Source files
------------

// File: rtl/next_pc_ctrl.sv
// Fetch-stage next-PC controller: owns the architectural PC, arbitrates redirect
// sources and runs a small edge-triggered, non-nesting interrupt controller.
module next_pc_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              NUM_IRQ    = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [XLEN-1:0] VEC_BASE   = 'h100,
    parameter int              VEC_STRIDE = 16,
    parameter int              IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_predict,
    input  logic [XLEN-1:0]    branch_pc,
    input  logic               branch_undo,
    input  logic [XLEN-1:0]    pc_not_taken,
    input  logic               pcr_take,
    input  logic [XLEN-1:0]    pcr,
    input  logic               pci_take,
    input  logic [XLEN-1:0]    pci,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               eret,
    output logic [XLEN-1:0]    pc,
    output logic               in_isr,
    output logic               irq_taken,
    output logic [IDW-1:0]     irq_id,
    output logic [XLEN-1:0]    epc
);

    typedef enum logic {
        IDLE = 1'b0,
        ISR  = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] next_pending;
    logic [NUM_IRQ-1:0] edges;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack;
    logic [IDW-1:0]     winner;
    logic               armed;
    logic               redirect;
    logic               entry;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    vector;
    logic [XLEN-1:0]    next_pc;
    logic [XLEN-1:0]    entry_epc;

    // The first edge after reset only primes irq_q, so a line held high
    // across reset is not mistaken for a fresh request.
    assign edges    = armed ? (irq & ~irq_q) : '0;
    assign eligible = pending & ~irq_mask;
    assign redirect = branch_undo | pcr_take | pci_take;
    assign entry    = (state == IDLE) && (|eligible) && !stall && !redirect;
    assign pc_plus4 = pc + XLEN'(4);
    assign vector   = VEC_BASE + (XLEN'(winner) * XLEN'(VEC_STRIDE));
    assign entry_epc = branch_predict ? branch_pc : pc_plus4;
    assign in_isr   = (state == ISR);

    // Lowest eligible index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = IDW'(i);
            end
        end
    end

    always_comb begin
        ack = '0;
        if (entry) begin
            ack = NUM_IRQ'(1) << winner;
        end
        next_pending = (pending & ~ack) | edges;
    end

    always_comb begin
        next_pc    = pc_plus4;
        next_state = state;
        if (branch_undo) begin
            next_pc = pc_not_taken;
        end else if (pcr_take) begin
            next_pc = pcr;
        end else if (pci_take) begin
            next_pc = pci;
        end else if (entry) begin
            next_pc    = vector;
            next_state = ISR;
        end else if (eret && (state == ISR)) begin
            next_pc    = epc;
            next_state = IDLE;
        end else if (stall) begin
            next_pc = pc;
        end else if (branch_predict) begin
            next_pc = branch_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            irq_q     <= '0;
            pending   <= '0;
            armed     <= 1'b0;
            irq_taken <= 1'b0;
            irq_id    <= '0;
            epc       <= '0;
        end else begin
            state     <= next_state;
            pc        <= next_pc;
            irq_q     <= irq;
            pending   <= next_pending;
            armed     <= 1'b1;
            irq_taken <= entry;
            if (entry) begin
                irq_id <= winner;
                epc    <= entry_epc;
            end
        end
    end

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Directed testbench for next_pc_ctrl: sequential flow, redirect priority,
// interrupt entry/return, masking, deferral and asynchronous reset.
module tb_next_pc_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_predict;
    logic [31:0] branch_pc;
    logic        branch_undo;
    logic [31:0] pc_not_taken;
    logic        pcr_take;
    logic [31:0] pcr;
    logic        pci_take;
    logic [31:0] pci;
    logic [3:0]  irq;
    logic [3:0]  irq_mask;
    logic        eret;
    logic [31:0] pc;
    logic        in_isr;
    logic        irq_taken;
    logic [1:0]  irq_id;
    logic [31:0] epc;

    int tests_run = 0;
    int failed    = 0;

    next_pc_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_predict(branch_predict), .branch_pc(branch_pc),
        .branch_undo(branch_undo), .pc_not_taken(pc_not_taken),
        .pcr_take(pcr_take), .pcr(pcr), .pci_take(pci_take), .pci(pci),
        .irq(irq), .irq_mask(irq_mask), .eret(eret),
        .pc(pc), .in_isr(in_isr), .irq_taken(irq_taken), .irq_id(irq_id), .epc(epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] addr);
        pcr_take = 1'b1;
        pcr      = addr;
        step();
        pcr_take = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        tests_run++;
        if ({pc, in_isr, irq_taken, irq_id, epc} !== {32'h0, 1'b0, 1'b0, 2'd0, 32'h0}) begin
            failed++;
            $display("[TB] FAIL reset_values: pc=%h isr=%b tk=%b id=%0d epc=%h, want all zero", pc, in_isr, irq_taken, irq_id, epc);
        end
        rst = 1'b0;
        step();
        tests_run++;
        if (pc !== 32'h4) begin failed++; $display("[TB] FAIL seq_4: pc=%h want 4", pc); end
        step();
        tests_run++;
        if (pc !== 32'h8) begin failed++; $display("[TB] FAIL seq_8: pc=%h want 8", pc); end
        step();
        tests_run++;
        if ({pc, in_isr, irq_taken, irq_id, epc} !== {32'hc, 1'b0, 1'b0, 2'd0, 32'h0}) begin
            failed++;
            $display("[TB] FAIL seq_c: pc=%h isr=%b tk=%b id=%0d epc=%h, want pc=c rest 0", pc, in_isr, irq_taken, irq_id, epc);
        end
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        tests_run++;
        if (pc !== 32'hFFFF_FFFC) begin failed++; $display("[TB] FAIL wrap_load: pc=%h want fffffffc", pc); end
        step();
        tests_run++;
        if (pc !== 32'h0) begin failed++; $display("[TB] FAIL wrap_zero: pc=%h want 0", pc); end
    endtask

    task automatic test_priority();
        pc_not_taken = 32'd20; pcr = 32'd40; pci = 32'd30; branch_pc = 32'd10;
        branch_undo = 1'b1; pcr_take = 1'b1; pci_take = 1'b1; branch_predict = 1'b1; stall = 1'b1;
        step();
        tests_run++;
        if (pc !== 32'd20) begin failed++; $display("[TB] FAIL prio_undo: pc=%0d want 20", pc); end
        branch_undo = 1'b0;
        step();
        tests_run++;
        if (pc !== 32'd40) begin failed++; $display("[TB] FAIL prio_pcr: pc=%0d want 40", pc); end
        pcr_take = 1'b0;
        step();
        tests_run++;
        if (pc !== 32'd30) begin failed++; $display("[TB] FAIL prio_pci: pc=%0d want 30", pc); end
        pci_take = 1'b0;
        step();
        tests_run++;
        if (pc !== 32'd30) begin failed++; $display("[TB] FAIL prio_stall_predict: pc=%0d want 30", pc); end
        branch_predict = 1'b0;
        step();
        tests_run++;
        if (pc !== 32'd30) begin failed++; $display("[TB] FAIL prio_stall: pc=%0d want 30", pc); end
        stall = 1'b0; branch_predict = 1'b1;
        step();
        tests_run++;
        if (pc !== 32'd10) begin failed++; $display("[TB] FAIL prio_predict: pc=%0d want 10", pc); end
        branch_predict = 1'b0;
        step();
        tests_run++;
        if (pc !== 32'd14) begin failed++; $display("[TB] FAIL prio_seq: pc=%0d want 14", pc); end
    endtask

    task automatic test_irq_entry();
        pcr_take = 1'b1; pcr = 32'h40; irq = 4'b0100;
        step();
        pcr_take = 1'b0;
        tests_run++;
        if ({pc, in_isr, irq_taken} !== {32'h40, 1'b0, 1'b0}) begin
            failed++; $display("[TB] FAIL entry_pre: pc=%h isr=%b tk=%b want 40/0/0", pc, in_isr, irq_taken);
        end
        step();
        tests_run++;
        if ({pc, in_isr, irq_taken, irq_id, epc} !== {32'h120, 1'b1, 1'b1, 2'd2, 32'h44}) begin
            failed++; $display("[TB] FAIL entry_irq2: pc=%h isr=%b tk=%b id=%0d epc=%h want 120/1/1/2/44", pc, in_isr, irq_taken, irq_id, epc);
        end
        step();
        tests_run++;
        if ({pc, in_isr, irq_taken} !== {32'h124, 1'b1, 1'b0}) begin
            failed++; $display("[TB] FAIL entry_pulse: pc=%h isr=%b tk=%b want 124/1/0", pc, in_isr, irq_taken);
        end
        step();
        eret = 1'b1;
        step();
        eret = 1'b0;
        tests_run++;
        if ({pc, in_isr, irq_id, epc} !== {32'h44, 1'b0, 2'd2, 32'h44}) begin
            failed++; $display("[TB] FAIL eret_return: pc=%h isr=%b id=%0d epc=%h want 44/0/2/44", pc, in_isr, irq_id, epc);
        end
        irq = 4'b0000;
        step();
        tests_run++;
        if ({pc, in_isr} !== {32'h48, 1'b0}) begin failed++; $display("[TB] FAIL eret_seq: pc=%h isr=%b want 48/0", pc, in_isr); end
    endtask

    task automatic test_mask_arbitration();
        set_pc(32'h200);
        irq_mask = 4'b0010; irq = 4'b1010;
        step();
        tests_run++;
        if ({pc, in_isr} !== {32'h204, 1'b0}) begin failed++; $display("[TB] FAIL mask_pend: pc=%h isr=%b want 204/0", pc, in_isr); end
        step();
        tests_run++;
        if ({pc, in_isr, irq_taken, irq_id, epc} !== {32'h130, 1'b1, 1'b1, 2'd3, 32'h208}) begin
            failed++; $display("[TB] FAIL mask_win3: pc=%h isr=%b tk=%b id=%0d epc=%h want 130/1/1/3/208", pc, in_isr, irq_taken, irq_id, epc);
        end
        irq[3] = 1'b0;
        step();
        irq[3] = 1'b1;
        step();
        step();
        tests_run++;
        if ({pc, in_isr, irq_taken, epc} !== {32'h13c, 1'b1, 1'b0, 32'h208}) begin
            failed++; $display("[TB] FAIL no_nesting: pc=%h isr=%b tk=%b epc=%h want 13c/1/0/208", pc, in_isr, irq_taken, epc);
        end
        eret = 1'b1;
        step();
        eret = 1'b0;
        tests_run++;
        if ({pc, in_isr} !== {32'h208, 1'b0}) begin failed++; $display("[TB] FAIL mask_eret1: pc=%h isr=%b want 208/0", pc, in_isr); end
        step();
        tests_run++;
        if ({pc, in_isr, irq_taken, irq_id, epc} !== {32'h130, 1'b1, 1'b1, 2'd3, 32'h20c}) begin
            failed++; $display("[TB] FAIL deferred_line3: pc=%h isr=%b tk=%b id=%0d epc=%h want 130/1/1/3/20c", pc, in_isr, irq_taken, irq_id, epc);
        end
        eret = 1'b1;
        step();
        eret = 1'b0; irq_mask = 4'b0000; branch_predict = 1'b1; branch_pc = 32'h500;
        tests_run++;
        if ({pc, in_isr} !== {32'h20c, 1'b0}) begin failed++; $display("[TB] FAIL mask_eret2: pc=%h isr=%b want 20c/0", pc, in_isr); end
        step();
        branch_predict = 1'b0;
        tests_run++;
        if ({pc, in_isr, irq_taken, irq_id, epc} !== {32'h110, 1'b1, 1'b1, 2'd1, 32'h500}) begin
            failed++; $display("[TB] FAIL unmask_line1: pc=%h isr=%b tk=%b id=%0d epc=%h want 110/1/1/1/500", pc, in_isr, irq_taken, irq_id, epc);
        end
        eret = 1'b1;
        step();
        eret = 1'b0; irq = 4'b0000;
        tests_run++;
        if ({pc, in_isr} !== {32'h500, 1'b0}) begin failed++; $display("[TB] FAIL mask_eret3: pc=%h isr=%b want 500/0", pc, in_isr); end
    endtask

    task automatic test_deferral();
        set_pc(32'h300);
        irq[0] = 1'b1;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({pc, in_isr, irq_taken} !== {32'h304, 1'b0, 1'b0}) begin
                failed++; $display("[TB] FAIL defer_stall%0d: pc=%h isr=%b tk=%b want 304/0/0", i, pc, in_isr, irq_taken);
            end
        end
        stall = 1'b0; pcr_take = 1'b1; pcr = 32'h400;
        step();
        pcr_take = 1'b0;
        tests_run++;
        if ({pc, in_isr, irq_taken} !== {32'h400, 1'b0, 1'b0}) begin
            failed++; $display("[TB] FAIL defer_redirect: pc=%h isr=%b tk=%b want 400/0/0", pc, in_isr, irq_taken);
        end
        step();
        tests_run++;
        if ({pc, in_isr, irq_taken, irq_id, epc} !== {32'h100, 1'b1, 1'b1, 2'd0, 32'h404}) begin
            failed++; $display("[TB] FAIL defer_entry: pc=%h isr=%b tk=%b id=%0d epc=%h want 100/1/1/0/404", pc, in_isr, irq_taken, irq_id, epc);
        end
        stall = 1'b1; eret = 1'b1;
        step();
        stall = 1'b0; eret = 1'b0;
        tests_run++;
        if ({pc, in_isr} !== {32'h404, 1'b0}) begin failed++; $display("[TB] FAIL eret_under_stall: pc=%h isr=%b want 404/0", pc, in_isr); end
        eret = 1'b1;
        step();
        eret = 1'b0;
        tests_run++;
        if ({pc, in_isr} !== {32'h408, 1'b0}) begin failed++; $display("[TB] FAIL eret_idle: pc=%h isr=%b want 408/0", pc, in_isr); end
    endtask

    task automatic test_reset_mid_isr();
        irq[2] = 1'b1;
        step();
        step();
        tests_run++;
        if ({pc, in_isr, irq_id} !== {32'h120, 1'b1, 2'd2}) begin
            failed++; $display("[TB] FAIL pre_reset_entry: pc=%h isr=%b id=%0d want 120/1/2", pc, in_isr, irq_id);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({pc, in_isr, irq_taken, irq_id, epc} !== {32'h0, 1'b0, 1'b0, 2'd0, 32'h0}) begin
            failed++; $display("[TB] FAIL async_reset: pc=%h isr=%b tk=%b id=%0d epc=%h want all zero", pc, in_isr, irq_taken, irq_id, epc);
        end
        #2 rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            tests_run++;
            if ({pc, in_isr, irq_taken} !== {32'(4 * i), 1'b0, 1'b0}) begin
                failed++; $display("[TB] FAIL held_line_%0d: pc=%h isr=%b tk=%b want %h/0/0", i, pc, in_isr, irq_taken, 32'(4 * i));
            end
        end
        irq[2] = 1'b0;
        step();
        irq[2] = 1'b1;
        step();
        step();
        tests_run++;
        if ({pc, in_isr, irq_taken, irq_id, epc} !== {32'h120, 1'b1, 1'b1, 2'd2, 32'h18}) begin
            failed++; $display("[TB] FAIL new_edge_after_reset: pc=%h isr=%b tk=%b id=%0d epc=%h want 120/1/1/2/18", pc, in_isr, irq_taken, irq_id, epc);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_predict = 1'b0; branch_pc = '0;
        branch_undo = 1'b0; pc_not_taken = '0; pcr_take = 1'b0; pcr = '0;
        pci_take = 1'b0; pci = '0; irq = '0; irq_mask = '0; eret = 1'b0;
        test_reset();
        test_wrap();
        test_priority();
        test_irq_entry();
        test_mask_arbitration();
        test_deferral();
        test_reset_mid_isr();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
